// File: rtl/mul12_seq_ctrl.sv
// 12x12 unsigned multiply sequenced over four passes of an external shared 6x6 multiplier,
// with optional accumulation of each product into a sticky-overflow accumulator.
module mul12_seq_ctrl #(
  parameter int unsigned ACC_W = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      a,
  input  logic [11:0]      b,
  input  logic             acc_en,
  input  logic             clr_acc,
  output logic [5:0]       m_a,
  output logic [5:0]       m_b,
  input  logic [11:0]      m_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      product,
  output logic [ACC_W-1:0] acc,
  output logic             overflow
);

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] IDLE = 3'd0;
  localparam logic [ST_W-1:0] P0   = 3'd1;
  localparam logic [ST_W-1:0] P1   = 3'd2;
  localparam logic [ST_W-1:0] P2   = 3'd3;
  localparam logic [ST_W-1:0] P3   = 3'd4;
  localparam logic [ST_W-1:0] DONE = 3'd5;

  logic [ST_W-1:0]  state, state_nxt;
  logic [11:0]      a_q, b_q;
  logic             acc_en_q;
  logic [23:0]      psum, pass_sum;
  logic [ACC_W:0]   acc_add;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf_nxt;
  logic             acc_step;

  // Next state, multiplier operand select and running partial sum
  always_comb begin
    state_nxt = state;
    m_a       = 6'd0;
    m_b       = 6'd0;
    pass_sum  = psum;
    case (state)
      IDLE: if (in_valid) state_nxt = P0;
      P0: begin
        m_a       = a_q[5:0];
        m_b       = b_q[5:0];
        pass_sum  = 24'(m_p);
        state_nxt = P1;
      end
      P1: begin
        m_a       = a_q[5:0];
        m_b       = b_q[11:6];
        pass_sum  = psum + {6'd0, m_p, 6'd0};
        state_nxt = P2;
      end
      P2: begin
        m_a       = a_q[11:6];
        m_b       = b_q[5:0];
        pass_sum  = psum + {6'd0, m_p, 6'd0};
        state_nxt = P3;
      end
      P3: begin
        m_a       = a_q[11:6];
        m_b       = b_q[11:6];
        pass_sum  = psum + {m_p, 12'd0};
        state_nxt = DONE;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator update; a clear on the accumulate edge keeps only the new product
  always_comb begin
    acc_step = (state == P3) && acc_en_q;
    acc_add  = {1'b0, acc} + (ACC_W+1)'(pass_sum);
    acc_nxt  = acc;
    ovf_nxt  = overflow;
    if (acc_step) begin
      acc_nxt = acc_add[ACC_W-1:0];
      ovf_nxt = overflow | acc_add[ACC_W];
    end
    if (clr_acc) begin
      acc_nxt = acc_step ? ACC_W'(pass_sum) : '0;
      ovf_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_q       <= 12'd0;
      b_q       <= 12'd0;
      acc_en_q  <= 1'b0;
      psum      <= 24'd0;
      product   <= 24'd0;
      acc       <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      if (state == IDLE && in_valid) begin
        a_q      <= a;
        b_q      <= b;
        acc_en_q <= acc_en;
      end
      if (state == P0 || state == P1 || state == P2) psum <= pass_sum;
      if (state == P3) product <= pass_sum;
      acc      <= acc_nxt;
      overflow <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_mul12_seq_ctrl.sv
// Scoreboard bench for mul12_seq_ctrl: ACC_W=28 main instance plus an ACC_W=24 instance
// in lockstep for the overflow case; each instance gets its own behavioural 6x6 multiplier.
module tb_mul12_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, acc_en, clr_acc, out_ready;
  logic [11:0] a, b;

  logic        in_ready, out_valid, overflow;
  logic [5:0]  m_a, m_b;
  logic [11:0] m_p;
  logic [23:0] product;
  logic [27:0] acc;

  logic        in_ready24, out_valid24, overflow24;
  logic [5:0]  m_a24, m_b24;
  logic [11:0] m_p24;
  logic [23:0] product24;
  logic [23:0] acc24;

  int errors = 0;
  int checks = 0;

  logic [27:0] exp_acc = '0;
  logic        exp_ovf = 1'b0;
  logic [23:0] sb_p[$];
  logic [27:0] sb_acc[$];
  logic        sb_ovf[$];

  always #5 clk = ~clk;

  assign m_p   = {6'd0, m_a}   * {6'd0, m_b};
  assign m_p24 = {6'd0, m_a24} * {6'd0, m_b24};

  mul12_seq_ctrl #(.ACC_W(28)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .acc_en(acc_en), .clr_acc(clr_acc),
    .m_a(m_a), .m_b(m_b), .m_p(m_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .acc(acc), .overflow(overflow)
  );

  mul12_seq_ctrl #(.ACC_W(24)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready24),
    .a(a), .b(b), .acc_en(acc_en), .clr_acc(clr_acc),
    .m_a(m_a24), .m_b(m_b24), .m_p(m_p24),
    .out_valid(out_valid24), .out_ready(out_ready),
    .product(product24), .acc(acc24), .overflow(overflow24)
  );

  // One transaction: push expectation, drive, check passes, pop and compare on out_valid
  task automatic txn(input logic [11:0] ta, input logic [11:0] tb, input logic ten,
                     input logic clr3, input int hold);
    logic [23:0] p, ep, hp;
    logic [28:0] s;
    logic [27:0] ea, ha;
    logic        eo;
    logic [5:0]  ema, emb;
    int          n;
    p = 24'(ta) * 24'(tb);
    s = {1'b0, exp_acc} + 29'(p);
    if (ten) begin
      exp_acc = s[27:0];
      exp_ovf = exp_ovf | s[28];
    end
    if (clr3) begin
      exp_acc = ten ? 28'(p) : 28'd0;
      exp_ovf = 1'b0;
    end
    sb_p.push_back(p);
    sb_acc.push_back(exp_acc);
    sb_ovf.push_back(exp_ovf);

    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL in_ready_idle: got %0b exp 1", in_ready);
    end
    a = ta; b = tb; acc_en = ten; in_valid = 1'b1; out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0; a = 12'($urandom); b = 12'($urandom); acc_en = ~ten;
    for (int k = 0; k < 4; k++) begin
      ema = (k < 2) ? ta[5:0] : ta[11:6];
      emb = (k % 2 == 1) ? tb[11:6] : tb[5:0];
      checks++;
      if ({m_a, m_b} !== {ema, emb}) begin
        errors++;
        $display("FAIL m_operands pass%0d: got %0d,%0d exp %0d,%0d", k, m_a, m_b, ema, emb);
      end
      if (k == 3) clr_acc = clr3;
      @(negedge clk);
      clr_acc = 1'b0;
    end
    n = 0;
    while (out_valid !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL latency: out_valid late by %0d cycles (valid=%0b)", n, out_valid);
    end
    ep = sb_p.pop_front();
    ea = sb_acc.pop_front();
    eo = sb_ovf.pop_front();
    checks++;
    if (product !== ep) begin
      errors++; $display("FAIL product %0h*%0h: got %0h exp %0h", ta, tb, product, ep);
    end
    checks++;
    if (acc !== ea || overflow !== eo) begin
      errors++; $display("FAIL acc: got %0h/%0b exp %0h/%0b", acc, overflow, ea, eo);
    end
    if (hold > 0) begin
      hp = product; ha = acc;
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1; a = 12'($urandom); b = 12'($urandom);
        @(negedge clk);
        checks++;
        if (product !== hp || acc !== ha || in_ready !== 1'b0 || out_valid !== 1'b1 ||
            m_a !== 6'd0 || m_b !== 6'd0) begin
          errors++;
          $display("FAIL hold cyc%0d: p=%0h acc=%0h rdy=%0b vld=%0b m=%0d,%0d exp p=%0h acc=%0h rdy=0 vld=1 m=0,0",
                   i, product, acc, in_ready, out_valid, m_a, m_b, hp, ha);
        end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_acc = 1'b1;
    @(negedge clk);
    clr_acc = 1'b0;
    exp_acc = '0;
    exp_ovf = 1'b0;
    checks++;
    if (acc !== 28'd0 || overflow !== 1'b0 || acc24 !== 24'd0 || overflow24 !== 1'b0) begin
      errors++;
      $display("FAIL clr_acc: acc=%0h ovf=%0b acc24=%0h ovf24=%0b exp all 0", acc, overflow, acc24, overflow24);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; acc_en = 1'b0; clr_acc = 1'b0; out_ready = 1'b1;
    a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 24'd0 || acc !== 28'd0 ||
        overflow !== 1'b0 || m_a !== 6'd0 || m_b !== 6'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b vld=%0b p=%0h acc=%0h ovf=%0b m=%0d,%0d exp 1,0,0,0,0,0,0",
               in_ready, out_valid, product, acc, overflow, m_a, m_b);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    txn(12'd12, 12'd18, 1'b0, 1'b0, 0);
    txn(12'hFFF, 12'hFFF, 1'b0, 1'b0, 0);
    txn(12'hFC0, 12'h03F, 1'b0, 1'b0, 0);
    checks++;
    if (product !== 24'h03E040) begin
      errors++; $display("FAIL product_const: got %0h exp 03e040", product);
    end
  endtask

  task automatic test_accumulate();
    pulse_clr();
    txn(12'd100, 12'd200, 1'b1, 1'b0, 0);
    txn(12'd4095, 12'd1, 1'b1, 1'b0, 0);
    txn(12'd7, 12'd9, 1'b1, 1'b0, 0);
    checks++;
    if (acc !== 28'd24158 || overflow !== 1'b0) begin
      errors++; $display("FAIL acc_const: got %0d/%0b exp 24158/0", acc, overflow);
    end
    txn(12'd5, 12'd6, 1'b1, 1'b1, 0);
  endtask

  task automatic test_acc24_overflow();
    pulse_clr();
    txn(12'hFFF, 12'hFFF, 1'b1, 1'b0, 0);
    txn(12'hFFF, 12'hFFF, 1'b1, 1'b0, 0);
    checks++;
    if (acc24 !== 24'hFFC002 || overflow24 !== 1'b1) begin
      errors++; $display("FAIL acc24_wrap: got %0h/%0b exp ffc002/1", acc24, overflow24);
    end
    pulse_clr();
  endtask

  task automatic test_hold();
    txn(12'd321, 12'd654, 1'b1, 1'b0, 10);
    txn(12'd17, 12'd23, 1'b1, 1'b0, 0);
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    a = 12'd999; b = 12'd888; acc_en = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    exp_acc = '0;
    exp_ovf = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 24'd0 || acc !== 28'd0) begin
      errors++;
      $display("FAIL reset_midflight: rdy=%0b vld=%0b p=%0h acc=%0h exp 1,0,0,0",
               in_ready, out_valid, product, acc);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL stale_result cyc%0d: out_valid=%0b exp 0", i, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    txn(12'd2048, 12'd3, 1'b1, 1'b0, 0);
    txn(12'd63, 12'd64, 1'b1, 1'b0, 0);
    txn(12'd0, 12'hABC, 1'b0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_accumulate();
    test_acc24_overflow();
    test_hold();
    test_reset_midflight();
    test_back_to_back();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
